// File: rtl/ctrl_decode_stage.sv
// MIPS ID control stage: decodes one accepted instruction into a registered control bundle (1-cycle latency).
// Backpressure: holds the bundle while out_ready is low; stalls intake on load-use hazards and during flush.
module ctrl_decode_stage #(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 8,
  parameter int EXT_OPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_reg_write,
  output logic             out_mem_to_reg,
  output logic             out_mem_write,
  output logic             out_branch,
  output logic             out_alu_src,
  output logic             out_alu_src_shamt,
  output logic             out_reg_dst,
  output logic             out_jump,
  output logic             out_link,
  output logic             out_jump_reg,
  output logic             out_illegal,
  output logic [3:0]       out_alu_control,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_dest,
  output logic [4:0]       out_shamt,
  output logic [XLEN-1:0]  out_imm,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_BEQ  = 4'b1001;
  localparam logic [3:0] ALU_BNE  = 4'b1010;
  localparam logic [3:0] ALU_ILL  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_J    = 4'b1101;
  localparam logic [3:0] ALU_JR   = 4'b1110;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [1:0] IMM_NONE = 2'd0;
  localparam logic [1:0] IMM_SX   = 2'd1;
  localparam logic [1:0] IMM_ZX   = 2'd2;

  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_write;
    logic            branch;
    logic            alu_src;
    logic            alu_src_shamt;
    logic            reg_dst;
    logic            jump;
    logic            link;
    logic            jump_reg;
    logic            illegal;
    logic [3:0]      alu_control;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dest;
    logic [4:0]      shamt;
    logic [XLEN-1:0] imm;
  } bundle_t;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];

  bundle_t    dec;
  logic       legal;
  logic [1:0] imm_mode;

  always_comb begin
    dec       = '0;
    legal     = 1'b1;
    imm_mode  = IMM_NONE;
    case (opcode)
      6'h00: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        case (funct)
          6'h20, 6'h21: dec.alu_control = ALU_ADD;
          6'h22, 6'h23: dec.alu_control = ALU_SUB;
          6'h24:        dec.alu_control = ALU_AND;
          6'h25:        dec.alu_control = ALU_OR;
          6'h26:        dec.alu_control = ALU_XOR;
          6'h27:        dec.alu_control = ALU_NOR;
          6'h2a:        dec.alu_control = ALU_SLT;
          6'h00: begin dec.alu_control = ALU_SLL; dec.alu_src_shamt = 1'b1; end
          6'h02: begin dec.alu_control = ALU_SRL; dec.alu_src_shamt = 1'b1; end
          6'h03: begin dec.alu_control = ALU_SRA; dec.alu_src_shamt = 1'b1; end
          6'h04:        dec.alu_control = ALU_SLL;
          6'h06:        dec.alu_control = ALU_SRL;
          6'h07:        dec.alu_control = ALU_SRA;
          6'h08: begin
            dec.reg_write   = 1'b0;
            dec.reg_dst     = 1'b0;
            dec.jump_reg    = 1'b1;
            dec.alu_control = ALU_JR;
          end
          6'h2b: begin dec.alu_control = ALU_SLTU; legal = (EXT_OPS != 0); end
          default:      legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin dec.alu_control = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1; imm_mode = IMM_SX; end
      6'h0a: begin
        dec.alu_control = ALU_SLT; dec.alu_src = 1'b1; dec.reg_write = 1'b1; imm_mode = IMM_SX;
        legal = (EXT_OPS != 0);
      end
      6'h0c: begin dec.alu_control = ALU_AND; dec.alu_src = 1'b1; dec.reg_write = 1'b1; imm_mode = IMM_ZX; end
      6'h0d: begin dec.alu_control = ALU_OR;  dec.alu_src = 1'b1; dec.reg_write = 1'b1; imm_mode = IMM_ZX; end
      6'h0e: begin dec.alu_control = ALU_XOR; dec.alu_src = 1'b1; dec.reg_write = 1'b1; imm_mode = IMM_ZX; end
      6'h04: begin dec.alu_control = ALU_BEQ; dec.branch = 1'b1; imm_mode = IMM_SX; end
      6'h05: begin dec.alu_control = ALU_BNE; dec.branch = 1'b1; imm_mode = IMM_SX; end
      6'h23: begin
        dec.alu_control = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        dec.mem_to_reg  = 1'b1;    imm_mode = IMM_SX;
      end
      6'h2b: begin dec.alu_control = ALU_ADD; dec.alu_src = 1'b1; dec.mem_write = 1'b1; imm_mode = IMM_SX; end
      6'h02: begin dec.alu_control = ALU_J; dec.jump = 1'b1; end
      6'h03: begin dec.alu_control = ALU_J; dec.jump = 1'b1; dec.link = 1'b1; dec.reg_write = 1'b1; end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec             = '0;
      dec.illegal     = 1'b1;
      dec.alu_control = ALU_ILL;
      imm_mode        = IMM_NONE;
    end

    dec.rs    = rs;
    dec.rt    = rt;
    dec.shamt = shamt;
    // Destination only exists for writers; jal always links into $31.
    if (dec.reg_write) dec.dest = dec.link ? 5'd31 : (dec.reg_dst ? rd : rt);
    case (imm_mode)
      IMM_SX:  dec.imm = {{(XLEN-16){instr[15]}}, instr[15:0]};
      IMM_ZX:  dec.imm = {{(XLEN-16){1'b0}}, instr[15:0]};
      default: dec.imm = '0;
    endcase
  end

  bundle_t           bundle_q, bundle_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              uses_rt, hazard, accept;

  assign uses_rt = (opcode == 6'h00) || (opcode == 6'h04) || (opcode == 6'h05) || (opcode == 6'h2b);
  // Load-use: a held lw whose destination feeds the incoming instruction blocks intake.
  assign hazard  = valid_q && bundle_q.mem_to_reg && (bundle_q.dest != 5'd0) &&
                   ((bundle_q.dest == rs) || (uses_rt && (bundle_q.dest == rt)));
  assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    cnt_d    = cnt_q;
    if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec;
      if (dec.illegal && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end else if (flush || out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid         = valid_q;
  assign out_reg_write     = bundle_q.reg_write;
  assign out_mem_to_reg    = bundle_q.mem_to_reg;
  assign out_mem_write     = bundle_q.mem_write;
  assign out_branch        = bundle_q.branch;
  assign out_alu_src       = bundle_q.alu_src;
  assign out_alu_src_shamt = bundle_q.alu_src_shamt;
  assign out_reg_dst       = bundle_q.reg_dst;
  assign out_jump          = bundle_q.jump;
  assign out_link          = bundle_q.link;
  assign out_jump_reg      = bundle_q.jump_reg;
  assign out_illegal       = bundle_q.illegal;
  assign out_alu_control   = bundle_q.alu_control;
  assign out_rs            = bundle_q.rs;
  assign out_rt            = bundle_q.rt;
  assign out_dest          = bundle_q.dest;
  assign out_shamt         = bundle_q.shamt;
  assign out_imm           = bundle_q.imm;
  assign illegal_cnt       = cnt_q;

endmodule

// File: doc/ctrl_decode_stage.md
# ctrl_decode_stage

Registered, handshaked instruction-decode control stage for the 5-stage pipelined MIPS CPU; it sits between the IF/ID instruction register and the ID/EX register. It decodes one 32-bit instruction per accepted beat into the control bundle plus destination register, operand indices and extended immediate. It also provides:
- load-use hazard bubble insertion
- synchronous flush
- optional extended opcodes
- a saturating illegal-instruction counter

## Interface
- XLEN, 32, width of `out_imm` (≥16); immediates extend to XLEN.
- CNT_W, 8, width of the illegal-instruction counter.
- EXT_OPS, 1, 1 = also decode `slti` (op 0x0a) and `sltu` (op 0, funct 0x2b); 0 = both are illegal.

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction from IF/ID
- in_valid  in  1  `instr` is valid
- in_ready  out  1  stage accepts `instr` this cycle (combinational)
- flush  in  1  synchronous kill of the held and incoming instruction
- out_valid  out  1  control bundle valid
- out_ready  in  1  ID/EX accepts the bundle
- out_reg_write, out_mem_to_reg, out_mem_write, out_branch, out_alu_src, out_alu_src_shamt, out_reg_dst, out_jump, out_link, out_jump_reg, out_illegal  out  1 each  decoded controls
- out_alu_control  out  4  ALU operation code
- out_rs, out_rt, out_dest, out_shamt  out  5 each  source indices, write destination, shift amount
- out_imm  out  XLEN  extended immediate
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

## Operation
**ALU codes:**
- AND 0000, OR 0001, ADD 0010, XOR 0011
- SLL 0100, SRL 0101, SUB 0110, SLT 0111
- SRA 1000, BEQ 1001, BNE 1010, illegal 1011
- NOR 1100, J/JAL 1101, JR 1110, SLTU 1111

**Decode set:**
- R-type (op 0), by funct: add/addu 20/21, sub/subu 22/23, and 24, or 25, xor 26, nor 27, slt 2a, sll 00, srl 02, sra 03, sllv 04, srlv 06, srav 07, jr 08.
- I-type and jump, by op: addi/addiu 08/09, andi 0c, ori 0d, xori 0e, beq 04, bne 05, lw 23, sw 2b, j 02, jal 03.

**Control rules:**
- R-type arithmetic and shifts: reg_write=1, reg_dst=1.
- sll/srl/sra: alu_src_shamt=1.
- I-type arithmetic: alu_src=1.
- lw: mem_to_reg=1.
- sw: mem_write=1, reg_write=0.
- beq/bne: branch=1.
- j: jump=1.
- jal: jump=1, link=1, reg_write=1, out_dest=31.
- jr: jump_reg=1.
- slti: ALU code SLT, alu_src=1.
- sltu: SLTU, R-format.

**Field rules:**
- out_dest = reg_dst ? rd : rt. Forced 0 when reg_write=0.
- out_imm sign-extends imm16 for addi, addiu, slti, lw, sw, beq, bne. Zero-extends imm16 for andi, ori, xori. Equals 0 for all other instructions.

**Illegal instruction:**
- Any encoding not listed, including EXT_OPS=0 extensions.
- Output: illegal=1, ALU code 1011, every enable 0, dest 0.
- Counter increments on acceptance and saturates at 2^CNT_W−1.

**Hazard:**
- hazard = out_valid & out_mem_to_reg & out_dest≠0 & (out_dest==instr.rs | (uses_rt & out_dest==instr.rt)).
- uses_rt is true for R-type, beq, bne and sw.

**Handshake:**
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Accept (in_valid & in_ready): the bundle is loaded and out_valid=1 next edge.
- Output consumed without a new accept: out_valid=0.
- out_valid=1 & !out_ready: the bundle holds stable.

**Flush:**
- Next edge: out_valid=0.
- No accept occurs that cycle; no count.
- Flush overrides hazard and handshake.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction per cycle when out_ready=1 and no hazard.
- Load-use: the dependent instruction is stalled while the lw is held; after the lw is consumed, one bubble cycle (out_valid=0), then accept. Exactly one bubble when out_ready=1 throughout.
- Reset (rst_n low, asynchronous): out_valid=0, all out_* = 0, illegal_cnt=0.
- in_ready reflects combinational state; acceptance is ignored while rst_n is low.
- Reset deasserted mid-stall: the stage restarts empty.
- Outputs are registered; only in_ready is combinational, from in_valid, instr, flush, out_ready and state.

## Test plan
- add $3,$1,$2 (0x00221820) with out_ready=1 -> next cycle out_valid=1, reg_write=1, reg_dst=1, alu 0010, dest 3.
- lw $5,4($1), then add $6,$5,$2 -> one bubble cycle (out_valid=0), add accepted the following cycle; no bubble if the add uses $7 instead.
- andi $2,$1,0x8000 and addi $2,$1,0x8000 -> out_imm 0x00008000 and 0xFFFF8000 respectively (XLEN=32).
- out_ready=0 for 3 cycles with in_valid=1 -> bundle stable, in_ready=0; then flush=1 -> out_valid=0 next edge, nothing accepted.
- 260 accepted 0xFC000000 instructions with CNT_W=8 -> illegal=1, ALU 1011, illegal_cnt saturates at 255; sltu decoded with EXT_OPS=1 (ALU 1111) and illegal with EXT_OPS=0.
- jal 0x0C000010 -> jump=1, link=1, reg_write=1, dest 31; assert rst_n low mid-stream -> all outputs 0 immediately.
